// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port IDs and
// the burst counter width.
package dmem_arb_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int BCNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        input  mem_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        output mem_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that was not
// granted last wins. Output is one-hot or zero.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        gnt[PORT_C] = req[PORT_C] & (~req[PORT_D] | (last == PORT_D));
        gnt[PORT_D] = req[PORT_D] & (~req[PORT_C] | (last == PORT_C));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port data memory between the CPU (C)
// and a DMA/loader port (D), with a bounded locked burst for D.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic reset,
    dmem_arbiter_if.slave bus
);

    localparam bit              BURST_EN   = (MAX_BURST > 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              rd_c_q, rd_c_d;
    logic              rd_d_q, rd_d_d;

    logic [1:0]        pick_gnt;
    logic              c_gnt;
    logic              d_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    rr_pick2 u_pick (
        .req  ({bus.d_req, bus.c_req}),
        .last (last_q),
        .gnt  (pick_gnt)
    );

    // Grants are masked while reset is held so every output reads zero.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (state_q == ST_ARB) begin
                c_gnt = pick_gnt[PORT_C];
                d_gnt = pick_gnt[PORT_D];
            end else begin
                d_gnt = bus.d_req;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_addr  = bus.c_addr;
            mem_we    = bus.c_we;
            mem_wdata = bus.c_wdata;
        end else if (d_gnt) begin
            mem_addr  = bus.d_addr;
            mem_we    = bus.d_we;
            mem_wdata = bus.d_wdata;
        end
    end

    // The burst ends after MAX_BURST grants counting the opening ARB cycle;
    // last stays D, so a waiting CPU wins the following cycle.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        rd_c_d  = c_gnt & ~bus.c_we;
        rd_d_d  = d_gnt & ~bus.d_we;
        if (c_gnt) begin
            last_d = PORT_C;
        end else if (d_gnt) begin
            last_d = PORT_D;
        end
        case (state_q)
            ST_ARB: begin
                if (d_gnt && bus.d_lock && BURST_EN) begin
                    state_d = ST_BURST;
                    bcnt_d  = BCNT_W'(1);
                end
            end
            ST_BURST: begin
                if (bus.d_req && bus.d_lock && (bcnt_q < BURST_LAST)) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else begin
                    state_d = ST_ARB;
                    bcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_ARB;
                bcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            last_q  <= PORT_D;
            bcnt_q  <= '0;
            rd_c_q  <= 1'b0;
            rd_d_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            rd_c_q  <= rd_c_d;
            rd_d_q  <= rd_d_d;
        end
    end

    assign bus.c_gnt     = c_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.c_rvalid  = rd_c_q;
    assign bus.d_rvalid  = rd_d_q;
    assign bus.c_rdata   = rd_c_q ? bus.mem_rdata : '0;
    assign bus.d_rdata   = rd_d_q ? bus.mem_rdata : '0;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   test_count;
    int   fail_count;

    logic [31:0] mem [0:2047];

    dmem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W    (11),
        .DATA_W    (32),
        .MAX_BURST (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic creq, input logic cwe, input logic [10:0] caddr,
                                  input logic [31:0] cwdata, input logic dreq, input logic dwe,
                                  input logic [10:0] daddr, input logic [31:0] dwdata,
                                  input logic dlock);
        bus.c_req   = creq;
        bus.c_we    = cwe;
        bus.c_addr  = caddr;
        bus.c_wdata = cwdata;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
        bus.d_lock  = dlock;
        #1;
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h010] = 32'hDEADBEEF;

        // Reset held with both ports requesting: everything must read zero.
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b1, 11'h005, 32'h1111_1111, 1'b1, 1'b1, 11'h006, 32'h2222_2222, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        check_output("rst_c_gnt", {31'b0, bus.c_gnt}, 32'd0);
        check_output("rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        check_output("rst_mem_addr", {21'b0, bus.mem_addr}, 32'd0);
        check_output("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_output("rst_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
        check_output("rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        check_output("rst_c_rdata", bus.c_rdata, 32'd0);

        // First tie after reset goes to C, then D.
        bus.d_lock = 1'b0;
        reset = 1'b1;
        #1;
        check_output("post_rst_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        check_output("post_rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        check_output("post_rst_mem_addr", {21'b0, bus.mem_addr}, 32'h005);
        tick();
        #1;
        check_output("post_rst_tie2_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
        check_output("post_rst_tie2_mem_addr", {21'b0, bus.mem_addr}, 32'h006);
        tick();

        // Idle: no grant, memory bus zero.
        apply_stimulus(1'b0, 1'b0, 11'h3FF, 32'hFFFF_FFFF, 1'b0, 1'b1, 11'h3FE, 32'hFFFF_FFFF, 1'b0);
        check_output("idle_gnt", {30'b0, bus.d_gnt, bus.c_gnt}, 32'd0);
        check_output("idle_mem_addr", {21'b0, bus.mem_addr}, 32'd0);
        check_output("idle_mem_wdata", bus.mem_wdata, 32'd0);
        tick();

        // CPU read only.
        apply_stimulus(1'b1, 1'b0, 11'h010, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        check_output("cread_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        check_output("cread_mem_addr", {21'b0, bus.mem_addr}, 32'h010);
        check_output("cread_mem_we", {31'b0, bus.mem_we}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        check_output("cread_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
        check_output("cread_c_rdata", bus.c_rdata, 32'hDEADBEEF);
        check_output("cread_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        tick();
        #1;
        check_output("cread_rvalid_drop", {31'b0, bus.c_rvalid}, 32'd0);

        // D-only write so that last=D before the alternation run.
        apply_stimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b1, 1'b1, 11'h030, 32'h0000_1234, 1'b0);
        check_output("donly_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
        tick();

        // Both requesting, no lock: C,D,C,D,C,D.
        apply_stimulus(1'b1, 1'b1, 11'h011, 32'hC0C0_0001, 1'b1, 1'b1, 11'h022, 32'hD0D0_0002, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("alt%0d_c_gnt", i), {31'b0, bus.c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_output($sformatf("alt%0d_d_gnt", i), {31'b0, bus.d_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check_output($sformatf("alt%0d_mem_addr", i), {21'b0, bus.mem_addr},
                         (i % 2 == 0) ? 32'h011 : 32'h022);
            tick();
        end

        // CPU-only write so that last=C, then an 8-beat locked DMA burst.
        apply_stimulus(1'b1, 1'b1, 11'h040, 32'h4040_4040, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        check_output("pre_burst_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b1, 11'h041, 32'h4141_4141, 1'b1, 1'b1, 11'(11'h100 + i),
                           32'hA000_0000 + i, 1'b1);
            check_output($sformatf("burst%0d_d_gnt", i), {31'b0, bus.d_gnt}, 32'd1);
            check_output($sformatf("burst%0d_c_gnt", i), {31'b0, bus.c_gnt}, 32'd0);
            check_output($sformatf("burst%0d_mem_addr", i), {21'b0, bus.mem_addr}, 32'h100 + i);
            tick();
        end
        apply_stimulus(1'b1, 1'b1, 11'h041, 32'h4141_4141, 1'b1, 1'b1, 11'h108, 32'hA000_0008, 1'b1);
        check_output("burst_end_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        check_output("burst_end_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("burst_mem%0d", i), mem[11'h100 + i], 32'hA000_0000 + i);
        end
        check_output("burst_mem_cpu", mem[11'h041], 32'h4141_4141);
        tick();

        // last=C: DMA write wins, CPU read of same word follows and sees it.
        apply_stimulus(1'b1, 1'b0, 11'h020, 32'h0, 1'b1, 1'b1, 11'h020, 32'h0000_0055, 1'b0);
        check_output("wr_rd_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
        check_output("wr_rd_mem_we", {31'b0, bus.mem_we}, 32'd1);
        check_output("wr_rd_c_wait", {31'b0, bus.c_gnt}, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 11'h020, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        check_output("wr_rd_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        check_output("wr_rd_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        check_output("wr_rd_c_rvalid", {31'b0, bus.c_rvalid}, 32'd1);
        check_output("wr_rd_c_rdata", bus.c_rdata, 32'h0000_0055);
        tick();

        // Locked DMA read burst, reset during its third cycle.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 1'b1, 11'h050, 32'h0, 1'b1, 1'b0, 11'(11'h100 + i), 32'h0, 1'b1);
            check_output($sformatf("rburst%0d_d_gnt", i), {31'b0, bus.d_gnt}, 32'd1);
            tick();
        end
        apply_stimulus(1'b1, 1'b1, 11'h050, 32'h0, 1'b1, 1'b0, 11'h102, 32'h0, 1'b1);
        check_output("rburst2_d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
        check_output("rburst2_d_rdata", bus.d_rdata, 32'hA000_0001);
        reset = 1'b0;
        #1;
        check_output("mid_rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        check_output("mid_rst_d_rdata", bus.d_rdata, 32'd0);
        check_output("mid_rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        tick();
        bus.d_lock = 1'b0;
        reset = 1'b1;
        #1;
        check_output("after_rst_c_gnt", {31'b0, bus.c_gnt}, 32'd1);
        check_output("after_rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
